// File: rtl/top_inter.sv
// top_inter: ping-pong block interleaver for the sample stream.
// Each ROWS*COLS frame is written row-major into one bank while the previous
// frame is read column-major from the other bank, one output per accepted input.
// Optional feature macro INTLV_SOF_EN adds sof_out, marking the first output
// sample of each frame.
module top_inter #(
    parameter int unsigned DW   = 11,
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 1536
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_in,
    input  logic [DW-1:0] in_data,
    output logic          en_out,
    output logic [DW-1:0] out_data,
    output logic          frame_err
`ifdef INTLV_SOF_EN
    ,
    output logic          sof_out
`endif
);

    localparam int unsigned DEPTH = ROWS * COLS;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW    = (COLS > 1) ? $clog2(COLS) : 1;

    // Two frame banks; bank index selects the half being written or read
    logic [DW-1:0] mem [2][DEPTH];

    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          wbank;
    logic          bank_valid;
    logic          en_in_q;

    logic [AW-1:0] w_addr_c;
    logic [AW-1:0] r_addr_c;
    logic          w_last_c;
    logic          rd_en_c;
    logic          w_nonzero_c;

    // Address generation and handshake qualifiers
    always_comb begin
        w_addr_c    = AW'(w_row) * AW'(COLS) + AW'(w_col);
        r_addr_c    = AW'(r_row) * AW'(COLS) + AW'(r_col);
        w_last_c    = (w_row == RW'(ROWS - 1)) && (w_col == CW'(COLS - 1));
        rd_en_c     = en_in && bank_valid;
        w_nonzero_c = (w_row != '0) || (w_col != '0);
    end

    // Sample storage write port; contents survive reset
    always_ff @(posedge clk) begin
        if (en_in) begin
            mem[wbank][w_addr_c] <= in_data;
        end
    end

    // Write counters (column inner), bank swap at the end of each frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_row      <= '0;
            w_col      <= '0;
            wbank      <= 1'b0;
            bank_valid <= 1'b0;
        end else if (en_in) begin
            if (w_col == CW'(COLS - 1)) begin
                w_col <= '0;
                if (w_row == RW'(ROWS - 1)) begin
                    w_row <= '0;
                end else begin
                    w_row <= w_row + RW'(1);
                end
            end else begin
                w_col <= w_col + CW'(1);
            end
            if (w_last_c) begin
                wbank      <= ~wbank;
                bank_valid <= 1'b1;
            end
        end
    end

    // Read counters (row inner); wrap lands on the same edge as the write wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (rd_en_c) begin
            if (r_row == RW'(ROWS - 1)) begin
                r_row <= '0;
                if (r_col == CW'(COLS - 1)) begin
                    r_col <= '0;
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end else begin
                r_row <= r_row + RW'(1);
            end
        end
    end

    // Registered read of the idle bank; out_data holds between outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_out   <= 1'b0;
            out_data <= '0;
        end else begin
            en_out <= rd_en_c;
            if (rd_en_c) begin
                out_data <= mem[~wbank][r_addr_c];
            end
        end
    end

    // Sticky flag for en_in dropping while a frame is partially written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_in_q   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            en_in_q <= en_in;
            if (en_in_q && !en_in && w_nonzero_c) begin
                frame_err <= 1'b1;
            end
        end
    end

`ifdef INTLV_SOF_EN
    // Start-of-frame marker aligned with the first column-major output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sof_out <= 1'b0;
        end else begin
            sof_out <= rd_en_c && (r_row == '0) && (r_col == '0);
        end
    end
`endif

endmodule

// File: tb/tb_top_inter.sv
// Directed bench for top_inter: a small 4x6 instance for the protocol cases
// and a default-size instance for a full two-frame pass.
module tb_top_inter;

    logic        clk;
    logic        rst;

    logic        s_en;
    logic [10:0] s_data;
    logic        s_en_out;
    logic [10:0] s_out;
    logic        s_err;

    logic        d_en;
    logic [10:0] d_data;
    logic        d_en_out;
    logic [10:0] d_out;
    logic        d_err;

`ifdef INTLV_SOF_EN
    logic        s_sof;
    logic        d_sof;
`endif

    int checks;
    int errors;

    // Column-major read order of a 4x6 frame holding 0..23 row-major
    int exp_tbl [24] = '{0, 6, 12, 18, 1, 7, 13, 19, 2, 8, 14, 20,
                         3, 9, 15, 21, 4, 10, 16, 22, 5, 11, 17, 23};

    top_inter #(.DW(11), .ROWS(4), .COLS(6)) u_small (
        .clk       (clk),
        .rst       (rst),
        .en_in     (s_en),
        .in_data   (s_data),
        .en_out    (s_en_out),
        .out_data  (s_out),
        .frame_err (s_err)
`ifdef INTLV_SOF_EN
        ,
        .sof_out   (s_sof)
`endif
    );

    top_inter u_dflt (
        .clk       (clk),
        .rst       (rst),
        .en_in     (d_en),
        .in_data   (d_data),
        .en_out    (d_en_out),
        .out_data  (d_out),
        .frame_err (d_err)
`ifdef INTLV_SOF_EN
        ,
        .sof_out   (d_sof)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [10:0] dval(input int k);
        return 11'((k * 37 + 5) ^ (k >> 5));
    endfunction

    // Drive the small instance for one cycle; outputs settle just after the edge
    task automatic tick(input logic en, input logic [10:0] d);
        @(negedge clk);
        s_en   = en;
        s_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b0;
        s_en = 1'b0;
        d_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Feed nframes of base+k into the small instance and check every cycle
    task automatic run_small(input int base, input bit gaps, input int nframes);
        int          j;
        int          fr;
        logic [10:0] expv;
        logic [10:0] last_out;
        last_out = 11'd0;
        for (int k = 0; k < nframes * 24; k++) begin
            tick(1'b1, 11'(base + k));
            checks++;
            if (k < 24) begin
                if (s_en_out !== 1'b0) begin
                    errors++;
                    $display("FAIL frame0_quiet k=%0d en_out got %b want 0", k, s_en_out);
                end
            end else begin
                j    = (k - 24) % 24;
                fr   = (k - 24) / 24;
                expv = 11'(base + fr * 24 + exp_tbl[j]);
                if (s_en_out !== 1'b1 || s_out !== expv) begin
                    errors++;
                    $display("FAIL interleave k=%0d got en=%b data=%0d want en=1 data=%0d",
                             k, s_en_out, s_out, expv);
                end
                last_out = expv;
            end
`ifdef INTLV_SOF_EN
            checks++;
            if (s_sof !== ((k >= 24) && ((k % 24) == 0))) begin
                errors++;
                $display("FAIL sof k=%0d got %b want %b", k, s_sof,
                         (k >= 24) && ((k % 24) == 0));
            end
`endif
            if (gaps) begin
                tick(1'b0, 11'h7ff);
                checks++;
                if (s_en_out !== 1'b0 || s_out !== last_out || s_err !== 1'b1) begin
                    errors++;
                    $display("FAIL gap k=%0d got en=%b data=%0d err=%b want en=0 data=%0d err=1",
                             k, s_en_out, s_out, s_err, last_out);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #5;
        rst = 1'b0;
        #1;
        checks++;
        if (s_en_out !== 1'b0 || s_out !== 11'd0 || s_err !== 1'b0 || d_en_out !== 1'b0) begin
            errors++;
            $display("FAIL reset got en=%b data=%0d err=%b den=%b want 0 0 0 0",
                     s_en_out, s_out, s_err, d_en_out);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_continuous();
        do_reset();
        run_small(0, 1'b0, 2);
        checks++;
        if (s_err !== 1'b0) begin
            errors++;
            $display("FAIL cont_err got %b want 0", s_err);
        end
        // Dropping en_in on a frame boundary: no output, data held, no error
        tick(1'b0, 11'd0);
        checks++;
        if (s_en_out !== 1'b0 || s_out !== 11'd23 || s_err !== 1'b0) begin
            errors++;
            $display("FAIL boundary_drop got en=%b data=%0d err=%b want en=0 data=23 err=0",
                     s_en_out, s_out, s_err);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        run_small(0, 1'b1, 2);
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 30; k++) begin
            tick(1'b1, 11'(k));
        end
        checks++;
        if (s_en_out !== 1'b1 || s_out !== 11'd7) begin
            errors++;
            $display("FAIL pre_reset got en=%b data=%0d want en=1 data=7", s_en_out, s_out);
        end
        @(negedge clk);
        s_en = 1'b0;
        rst  = 1'b0;
        #1;
        checks++;
        if (s_en_out !== 1'b0 || s_out !== 11'd0 || s_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got en=%b data=%0d err=%b want 0 0 0",
                     s_en_out, s_out, s_err);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_small(100, 1'b0, 2);
        checks++;
        if (s_err !== 1'b0) begin
            errors++;
            $display("FAIL restart_err got %b want 0", s_err);
        end
    endtask

    task automatic test_sof();
        do_reset();
        run_small(0, 1'b0, 3);
    endtask

    // Default 8x1536 instance: same vector twice, check the second pass
    task automatic test_default();
        int          r;
        int          c;
        logic [10:0] expv;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 12288; k++) begin
                @(negedge clk);
                d_en   = 1'b1;
                d_data = dval(k);
                @(posedge clk);
                #1;
                checks++;
                if (p == 0) begin
                    if (d_en_out !== 1'b0) begin
                        errors++;
                        $display("FAIL dflt_quiet k=%0d en_out got %b want 0", k, d_en_out);
                    end
                end else begin
                    c    = k / 8;
                    r    = k % 8;
                    expv = dval(r * 1536 + c);
                    if (d_en_out !== 1'b1 || d_out !== expv) begin
                        errors++;
                        $display("FAIL dflt k=%0d got en=%b data=%0d want en=1 data=%0d",
                                 k, d_en_out, d_out, expv);
                    end
                end
            end
        end
        @(negedge clk);
        d_en = 1'b0;
        checks++;
        if (d_err !== 1'b0) begin
            errors++;
            $display("FAIL dflt_err got %b want 0", d_err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        s_en   = 1'b0;
        s_data = 11'd0;
        d_en   = 1'b0;
        d_data = 11'd0;
        test_reset();
        test_continuous();
        test_gaps();
        test_reset_mid();
        test_sof();
        test_default();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
